// File: rtl/upg_pkg.sv
// Shared constants for the UART program loader: bit-period divider, rx FSM
// encodings, the done-acknowledge byte and the default word-address width.
package upg_pkg;

  localparam int ADDR_W_DEF = 15;

  localparam logic [7:0] DONE_ACK = 8'h55;

  // ST_BREAK parks the receiver after a framing error until the line returns high
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// LSB-first data sampling and stop-bit framing check.
module uart_rx_byte
  import upg_pkg::*;
#(
  parameter int DIV = 78
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_idle,
  output logic       o_start
);

  localparam logic [15:0] BIT_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  logic        r_sync1, r_sync2, r_prev;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_valid, r_ferr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (r_cnt == BIT_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              r_valid <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_BREAK: if (r_sync2) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_data      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_idle      = (r_state == ST_IDLE);
  assign o_start     = (r_state == ST_IDLE) && r_prev && !r_sync2;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program-upload engine: packs little-endian words into ROM/data-memory writes.
// Define UPG_ECHO_EN to add a transmitter that echoes bytes and sends 0x55 on done.
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 10_000_000,
  parameter int BAUD         = 128_000,
  parameter int TIMEOUT_BITS = 64,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              upg_rx_i,
  output logic              upg_clk_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_tx_o
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam logic [31:0]       TO_M1   = 32'(TIMEOUT_BITS * DIV - 1);
  localparam logic [ADDR_W-1:0] ADR_MAX = '1;

  logic [7:0]  w_rx_data;
  logic        w_rx_valid, w_frame_err, w_rx_idle, w_rx_start;
  logic        w_byte_ok, w_word, w_timeout, w_set_done;

  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_acc;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_dat;
  logic              r_wen, r_done, r_wrote;
  logic [31:0]       r_idle_cnt;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .i_clk       (upg_clk_i),
    .i_rst       (upg_rst_i),
    .i_rx        (upg_rx_i),
    .o_data      (w_rx_data),
    .o_valid     (w_rx_valid),
    .o_frame_err (w_frame_err),
    .o_idle      (w_rx_idle),
    .o_start     (w_rx_start)
  );

  assign w_byte_ok  = w_rx_valid && !r_done;
  assign w_word     = w_byte_ok && (r_byte_cnt == 2'd3);
  assign w_timeout  = r_wrote && !r_done && w_rx_idle && (r_idle_cnt == TO_M1);
  assign w_set_done = (w_word && (r_adr == ADR_MAX)) || (!w_word && w_timeout);

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      r_byte_cnt <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_wen      <= 1'b0;
      r_done     <= 1'b0;
      r_wrote    <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_wen <= w_word;
      // The last address never wraps; reaching it ends the upload instead
      if (r_wen && (r_adr != ADR_MAX)) r_adr <= r_adr + 1'b1;
      if (w_byte_ok) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_acc[7:0]   <= w_rx_data;
          2'd1:    r_acc[15:8]  <= w_rx_data;
          2'd2:    r_acc[23:16] <= w_rx_data;
          default: r_dat        <= {w_rx_data, r_acc};
        endcase
      end
      if (w_word) r_wrote <= 1'b1;
      if (w_set_done) r_done <= 1'b1;
      // A strobe in the same cycle takes priority; timeout drops any partial word
      if (!w_word && w_timeout) r_byte_cnt <= '0;
      if (w_rx_start || w_frame_err || !r_wrote || r_done) r_idle_cnt <= '0;
      else if (w_rx_idle) r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign upg_clk_o  = upg_clk_i;
  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;

`ifdef UPG_ECHO_EN
  localparam logic [15:0] BIT_M1 = 16'(DIV - 1);

  logic [7:0]  r_hold;
  logic        r_hold_vld, r_ack_pend, r_tx_busy, r_tx;
  logic [8:0]  r_tx_sh;
  logic [3:0]  r_tx_bits;
  logic [15:0] r_tx_cnt;

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      r_hold_vld <= 1'b0;
      r_ack_pend <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_bits  <= '0;
      r_tx_cnt   <= '0;
    end else begin
      if (w_set_done) r_ack_pend <= 1'b1;
      if (!r_tx_busy) begin
        // Pending echo goes out before the acknowledge byte
        if (r_hold_vld || r_ack_pend) begin
          r_tx      <= 1'b0;
          r_tx_sh   <= {1'b1, (r_hold_vld ? r_hold : DONE_ACK)};
          r_tx_bits <= '0;
          r_tx_cnt  <= '0;
          r_tx_busy <= 1'b1;
          if (r_hold_vld) r_hold_vld <= 1'b0;
          else            r_ack_pend <= 1'b0;
        end
      end else if (r_tx_cnt == BIT_M1) begin
        r_tx_cnt <= '0;
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx      <= r_tx_sh[0];
          r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
          r_tx_bits <= r_tx_bits + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      if (w_byte_ok && (!r_hold_vld || !r_tx_busy)) begin
        r_hold     <= w_rx_data;
        r_hold_vld <= 1'b1;
      end
    end
  end

  assign upg_tx_o = r_tx;
`else
  assign upg_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader at DIV=10, 8-bit-time timeout.
module tb_uart_prog_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        clk_o, wen, done, tx;
  logic [14:0] adr;
  logic [31:0] dat;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD        (1_000_000),
    .TIMEOUT_BITS(8),
    .ADDR_W      (15)
  ) dut (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .upg_rx_i  (rx),
    .upg_clk_o (clk_o),
    .upg_wen_o (wen),
    .upg_adr_o (adr),
    .upg_dat_o (dat),
    .upg_done_o(done),
    .upg_tx_o  (tx)
  );

  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
    logic        done;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_wen = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(DIV);
    end
    rx = stop;
    idle(DIV);
    rx = 1'b1;
    idle(stop ? 2 : DIV + 2);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic push_exp(input logic [14:0] a, input logic [31:0] d, input logic dn);
    wr_t t;
    t.adr  = a;
    t.dat  = d;
    t.done = dn;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  // Write-strobe monitor: every strobe must match the next scoreboard entry
  always @(negedge clk) begin
    if (wen) begin
      check("wen_one_cycle", prev_wen, 1'b0);
      check("strobe_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_adr", adr, e.adr);
        check("strobe_dat", dat, e.dat);
        check("strobe_done", done, e.done);
      end
    end
    prev_wen = wen;
  end

`ifdef UPG_ECHO_EN
  logic [7:0] echo_q[$];
  bit         mon_en = 1'b0;

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && tx == 1'b0) begin
        idle(DIV / 2);
        for (int i = 0; i < 8; i++) begin
          idle(DIV);
          b[i] = tx;
        end
        idle(DIV);
        check("echo_stop", tx, 1'b1);
        check("echo_expected", echo_q.size() != 0, 1'b1);
        if (echo_q.size() != 0) check("echo_byte", b, echo_q.pop_front());
      end
    end
  end
`endif

  initial begin
    // Reset values and zero-length upload
    do_reset();
    check("rst_wen", wen, 1'b0);
    check("rst_adr", adr, 15'h0);
    check("rst_dat", dat, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_tx", tx, 1'b1);
    check("clk_pass", clk_o, clk);
    idle(300);
    check("zero_len_done", done, 1'b0);

    // Basic word and address increment
    push_exp(15'h0, 32'h1234_5678, 1'b0);
    send_word(32'h1234_5678);
    check("adr_after_w0", adr, 15'h1);
    check("wen_low_after", wen, 1'b0);
    push_exp(15'h1, 32'hF0DE_BC9A, 1'b0);
    send_word(32'hF0DE_BC9A);
    check("adr_after_w1", adr, 15'h2);
    check("sb_empty_t1", exp_q.size(), 0);

    // Timeout after two words, then bytes are ignored
    do_reset();
    push_exp(15'h0, 32'h0302_0100, 1'b0);
    push_exp(15'h1, 32'h0706_0504, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    idle(60);
    check("done_not_early", done, 1'b0);
    idle(40);
    check("done_timeout", done, 1'b1);
    send_word(32'hDEAD_BEEF);
    idle(20);
    check("adr_frozen", adr, 15'h2);
    check("done_sticky", done, 1'b1);
    check("sb_empty_t2", exp_q.size(), 0);

    // Five bytes: one write, partial discarded at timeout
    do_reset();
    push_exp(15'h0, 32'h1312_1110, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
    idle(100);
    check("done_partial", done, 1'b1);
    check("adr_partial", adr, 15'h1);
    check("sb_empty_t3", exp_q.size(), 0);

    // Framing error byte is dropped
    do_reset();
    send_byte(8'h11, 1'b0);
    push_exp(15'h0, 32'hDDCC_BBAA, 1'b0);
    send_word(32'hDDCC_BBAA);
    check("adr_after_ferr", adr, 15'h1);
    check("sb_empty_t4", exp_q.size(), 0);

    // Last address: done rises with the strobe
    do_reset();
    force dut.r_adr = 15'h7FFF;
    push_exp(15'h7FFF, 32'hCAFE_F00D, 1'b1);
    send_word(32'hCAFE_F00D);
    check("done_at_max", done, 1'b1);
    check("adr_no_wrap", adr, 15'h7FFF);
    release dut.r_adr;
    check("sb_empty_t5", exp_q.size(), 0);
    do_reset();
    check("done_cleared", done, 1'b0);

    // Reset mid-word and mid-byte discards partial state
    send_byte(8'hEE);
    send_byte(8'hFF);
    rx = 1'b0;
    idle(3 * DIV);
    do_reset();
    check("rst_mid_adr", adr, 15'h0);
    check("rst_mid_dat", dat, 32'h0);
    push_exp(15'h0, 32'h4433_2211, 1'b0);
    send_word(32'h4433_2211);
    check("sb_empty_t6", exp_q.size(), 0);
    check("done_t6", done, 1'b0);
`ifndef UPG_ECHO_EN
    check("tx_const", tx, 1'b1);
`endif

`ifdef UPG_ECHO_EN
    // Echo of each byte, then a single acknowledge after timeout
    do_reset();
    echo_q = '{8'h3C, 8'h01, 8'h02, 8'h03, 8'h55};
    mon_en = 1'b1;
    push_exp(15'h0, 32'h0302_013C, 1'b0);
    send_word(32'h0302_013C);
    idle(100);
    check("echo_done", done, 1'b1);
    idle(400);
    check("echo_q_empty", echo_q.size(), 0);
    check("echo_tx_idle", tx, 1'b1);
    mon_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
